// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package rv_fetch_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Small synchronous FIFO of fetch entries; head is read straight from storage.
module ifq_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t  head_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push_i && (count_q < CW'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (!rst && !clear_i && push_ok) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: sequential single-outstanding ROM requests, redirect with
// discard of an in-flight response, and a small queue toward decode.
module inst_fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_rvalid_i,
  input  logic [31:0] rom_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          outstanding_q, outstanding_d;
  logic          discard_q, discard_d;
  logic [31:0]   req_addr_q, req_addr_d;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          pop;
  logic          resp;
  logic          live;
  logic [CW:0]   occupancy;
  logic          req;
  logic          push;

  assign inst_valid_o = (count != '0);
  assign pop          = inst_valid_o && inst_ready_i;
  assign resp         = rom_rvalid_i && outstanding_q;
  assign live         = outstanding_q && !discard_q;

  // Slots already committed after this cycle's pop, counting the live request.
  assign occupancy = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(live);
  assign req       = !rst && !jump_en_i && (!outstanding_q || rom_rvalid_i)
                     && (occupancy < (CW+1)'(DEPTH));
  assign push      = resp && !discard_q && !jump_en_i && !rst;

  assign push_entry = '{addr: req_addr_q, inst: rom_rdata_i};

  assign rom_req_o  = req;
  assign rom_addr_o = req ? fetch_pc_q : 32'h0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    req_addr_d    = req_addr_q;
    if (jump_en_i) begin
      fetch_pc_d = word_align(jump_addr_i);
      if (resp) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end else if (outstanding_q) begin
        discard_d = 1'b1;
      end
    end else begin
      if (resp) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end
      if (req) begin
        outstanding_d = 1'b1;
        req_addr_d    = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      req_addr_q    <= 32'h0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      req_addr_q    <= req_addr_d;
    end
  end

  ifq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .entry_i(push_entry),
    .pop_i  (pop && !jump_en_i),
    .clear_i(jump_en_i),
    .count_o(count),
    .head_o (head)
  );

  assign inst_o      = inst_valid_o ? head.inst : INST_NOP;
  assign inst_addr_o = inst_valid_o ? head.addr : 32'h0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a variable-latency ROM model.
module tb_inst_fetch_queue;
  import rv_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_rvalid_i;
  logic [31:0] rom_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;

  int n_cmp = 0;
  int n_err = 0;

  bit          rom_busy = 1'b0;
  int          rom_cnt  = 0;
  int          lat      = 1;
  logic [31:0] rom_addr_m = 32'h0;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_req_o   (rom_req_o),
    .rom_addr_o  (rom_addr_o),
    .rom_rvalid_i(rom_rvalid_i),
    .rom_rdata_i (rom_rdata_i),
    .inst_valid_o(inst_valid_o),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .inst_ready_i(inst_ready_i),
    .jump_en_i   (jump_en_i),
    .jump_addr_i (jump_addr_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic drive_rom();
    rom_rvalid_i = rom_busy && (rom_cnt == 1);
    rom_rdata_i  = rom_rvalid_i ? rom_word(rom_addr_m) : 32'hDEAD_BEEF;
  endtask

  // Latch this cycle's request into the ROM model, then advance one clock.
  task automatic step();
    if (rom_rvalid_i) rom_busy = 1'b0;
    else if (rom_busy) rom_cnt--;
    if (rom_req_o === 1'b1) begin
      rom_busy   = 1'b1;
      rom_cnt    = lat;
      rom_addr_m = rom_addr_o;
    end
    @(posedge clk);
    #1;
    drive_rom();
  endtask

  task automatic do_reset(input int latency);
    rst          = 1'b1;
    jump_en_i    = 1'b0;
    jump_addr_i  = 32'h0;
    inst_ready_i = 1'b0;
    repeat (4) begin
      #1;
      step();
    end
    lat = latency;
    #1;
    chk("rst req", rom_req_o, 32'd0);
    chk("rst addr", rom_addr_o, 32'h0);
    chk("rst valid", inst_valid_o, 32'd0);
    chk("rst inst", inst_o, 32'h0000_0013);
    chk("rst iaddr", inst_addr_o, 32'h0);
  endtask

  initial begin
    rst          = 1'b1;
    jump_en_i    = 1'b0;
    jump_addr_i  = 32'h0;
    inst_ready_i = 1'b0;
    drive_rom();

    // Streaming with a 1-cycle ROM.
    do_reset(1);
    rst = 1'b0; inst_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t1 req", rom_req_o, 32'd1);
      chk("t1 addr", rom_addr_o, 32'(4 * k));
      chk("t1 valid", inst_valid_o, 32'(k >= 2));
      if (k >= 2) begin
        chk("t1 iaddr", inst_addr_o, 32'(4 * (k - 2)));
        chk("t1 inst", inst_o, rom_word(32'(4 * (k - 2))));
      end
      step();
    end

    // Back-pressure: fill four entries, then one pop admits exactly one request.
    do_reset(1);
    rst = 1'b0; inst_ready_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t2 req", rom_req_o, 32'(k < 4));
      if (k < 4) chk("t2 addr", rom_addr_o, 32'(4 * k));
      step();
    end
    inst_ready_i = 1'b1;
    #1;
    chk("t2 full valid", inst_valid_o, 32'd1);
    chk("t2 pulse req", rom_req_o, 32'd1);
    chk("t2 pulse addr", rom_addr_o, 32'h10);
    chk("t2 head0", inst_addr_o, 32'h0);
    step();
    inst_ready_i = 1'b0;
    #1;
    chk("t2 after req", rom_req_o, 32'd0);
    chk("t2 head1", inst_addr_o, 32'h4);
    step();
    #1;
    chk("t2 resp req", rom_req_o, 32'd0);
    step();
    #1;
    chk("t2 hold req", rom_req_o, 32'd0);
    chk("t2 hold head", inst_addr_o, 32'h4);

    // 3-cycle ROM, redirect while a request is outstanding.
    do_reset(3);
    rst = 1'b0; inst_ready_i = 1'b1;
    #1;
    chk("t3 req0", rom_req_o, 32'd1);
    chk("t3 addr0", rom_addr_o, 32'h0);
    step();
    #1;
    chk("t3 wait req", rom_req_o, 32'd0);
    step();
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0103;
    #1;
    chk("t3 jump req", rom_req_o, 32'd0);
    step();
    jump_en_i = 1'b0;
    #1;
    chk("t3 drop rvalid", rom_rvalid_i, 32'd1);
    chk("t3 tgt req", rom_req_o, 32'd1);
    chk("t3 tgt addr", rom_addr_o, 32'h100);
    chk("t3 drop valid", inst_valid_o, 32'd0);
    step();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t3 gap req", rom_req_o, 32'd0);
      chk("t3 gap valid", inst_valid_o, 32'd0);
      step();
    end
    #1;
    chk("t3 next addr", rom_addr_o, 32'h104);
    chk("t3 pre valid", inst_valid_o, 32'd0);
    step();
    #1;
    chk("t3 valid", inst_valid_o, 32'd1);
    chk("t3 iaddr", inst_addr_o, 32'h100);
    chk("t3 inst", inst_o, rom_word(32'h100));

    // Redirect coinciding with a response and a pop.
    do_reset(1);
    rst = 1'b0; inst_ready_i = 1'b1;
    #1;
    chk("t4 addr0", rom_addr_o, 32'h0);
    step();
    #1;
    chk("t4 addr1", rom_addr_o, 32'h4);
    step();
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0200;
    #1;
    chk("t4 jcyc valid", inst_valid_o, 32'd1);
    chk("t4 jcyc rvalid", rom_rvalid_i, 32'd1);
    chk("t4 jcyc req", rom_req_o, 32'd0);
    step();
    jump_en_i = 1'b0;
    #1;
    chk("t4 empty", inst_valid_o, 32'd0);
    chk("t4 tgt req", rom_req_o, 32'd1);
    chk("t4 tgt addr", rom_addr_o, 32'h200);
    step();
    #1;
    chk("t4 next addr", rom_addr_o, 32'h204);
    chk("t4 still empty", inst_valid_o, 32'd0);
    step();
    #1;
    chk("t4 iaddr", inst_addr_o, 32'h200);

    // Address wrap, with unaligned low bits on the jump target.
    do_reset(1);
    rst = 1'b0; inst_ready_i = 1'b1;
    jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFE;
    #1;
    chk("t5 jump req", rom_req_o, 32'd0);
    step();
    jump_en_i = 1'b0;
    #1;
    chk("t5 addr top", rom_addr_o, 32'hFFFF_FFFC);
    step();
    #1;
    chk("t5 addr wrap", rom_addr_o, 32'h0);
    step();
    #1;
    chk("t5 iaddr top", inst_addr_o, 32'hFFFF_FFFC);
    chk("t5 inst top", inst_o, rom_word(32'hFFFF_FFFC));
    step();
    #1;
    chk("t5 iaddr wrap", inst_addr_o, 32'h0);

    // Reset with a loaded queue and an outstanding request; late response ignored.
    do_reset(3);
    rst = 1'b0; inst_ready_i = 1'b0;
    repeat (10) begin
      #1;
      step();
    end
    #1;
    chk("t6 loaded", inst_valid_o, 32'd1);
    chk("t6 head", inst_addr_o, 32'h0);
    rst = 1'b1;
    #1;
    chk("t6 rst req", rom_req_o, 32'd0);
    step();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t6 rst valid", inst_valid_o, 32'd0);
      chk("t6 rst inst", inst_o, 32'h0000_0013);
      chk("t6 rst iaddr", inst_addr_o, 32'h0);
      step();
    end
    rst = 1'b0;
    #1;
    chk("t6 first req", rom_req_o, 32'd1);
    chk("t6 first addr", rom_addr_o, 32'h0);
    chk("t6 no push", inst_valid_o, 32'd0);
    step();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t6 wait req", rom_req_o, 32'd0);
      chk("t6 wait valid", inst_valid_o, 32'd0);
      step();
    end
    #1;
    chk("t6 second addr", rom_addr_o, 32'h4);
    step();
    #1;
    chk("t6 valid", inst_valid_o, 32'd1);
    chk("t6 iaddr", inst_addr_o, 32'h0);
    chk("t6 inst", inst_o, rom_word(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front end that sits between the instruction ROM and `pc_reg`/`ifetch`, replacing the fixed one-cycle ROM assumption. It generates sequential fetch addresses, issues single-outstanding requests to a variable-latency ROM and buffers returned instructions with their addresses in a small queue. It hands them to decode through a valid/ready handshake and supports a redirect (jump) that flushes all in-flight and buffered instructions.

## Interface
- `DEPTH`, 4, number of queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rom_req_o`  out  1  fetch request; the ROM accepts it in the cycle it is high.
- `rom_addr_o`  out  32  fetch address, valid when `rom_req_o`=1; otherwise 0.
- `rom_rvalid_i`  in  1  response valid for the single outstanding request.
- `rom_rdata_i`  in  32  instruction word, valid with `rom_rvalid_i`.
- `inst_valid_o`  out  1  queue head holds a valid instruction.
- `inst_o`  out  32  head instruction; 32'h0000_0013 (NOP) when `inst_valid_o`=0.
- `inst_addr_o`  out  32  head instruction address; 0 when `inst_valid_o`=0.
- `inst_ready_i`  in  1  consumer takes the head this cycle when `inst_valid_o`=1.
- `jump_en_i`  in  1  redirect or flush request.
- `jump_addr_i`  in  32  redirect target; bits [1:0] are forced to 0.

## Operation
- State:
  - `fetch_pc` (next address to request).
  - `outstanding` flag.
  - `discard` flag.
  - queue of {addr, inst} entries with `count`.
  - the address of the outstanding request.
- Request condition, all terms required:
  - `!rst`
  - `!jump_en_i`
  - (`!outstanding` or `rom_rvalid_i`)
  - `count - pop + live < DEPTH`
- Terms in the request condition:
  - `pop` = `inst_valid_o & inst_ready_i`.
  - `live` = 1 if an outstanding, non-discarded request exists, including one returning this cycle.
- On a request: `rom_addr_o` = `fetch_pc`, then `fetch_pc` ← `fetch_pc`+4. The address wraps modulo 2^32.
- Response with `discard`=0: push {request addr, `rom_rdata_i`} and clear `outstanding`, unless a new request issues in the same cycle.
- Response with `discard`=1: drop the data, clear `discard`, push nothing.
- Pop: advance the head when `pop`=1. Push and pop in the same cycle leave `count` unchanged. The request condition makes overflow impossible.
- Redirect (`jump_en_i`=1), highest priority:
  - queue cleared (`count`←0).
  - `fetch_pc` ← {`jump_addr_i`[31:2], 2'b00}.
  - no request issued this cycle.
- In-flight request at redirect time:
  - If a request is outstanding and `rom_rvalid_i`=0: set `discard`.
  - If `rom_rvalid_i`=1 in the same cycle: the data is dropped and `outstanding` is cleared.
- Pop in the redirect cycle is ignored.
- A second redirect while `discard` is set only updates `fetch_pc`.
- A `rom_rvalid_i` with no outstanding request is ignored.

## Timing
- Reset values:
  - `rom_req_o`=0, `rom_addr_o`=0.
  - `inst_valid_o`=0, `inst_o`=NOP, `inst_addr_o`=0.
  - `fetch_pc`=`RESET_PC`, `count`=0, `outstanding`=0, `discard`=0.
- `rom_req_o` is combinational from state plus `rom_rvalid_i`, `inst_ready_i` and `jump_en_i`.
- Head outputs come straight from queue storage; there is no bypass.
- Latency from request to `inst_valid_o` is ROM latency + 1 cycle. With a 1-cycle ROM:
  - request at cycle N, `rom_rvalid_i` at N+1, `inst_valid_o` at N+2.
  - sustained throughput is 1 instruction/cycle.
- First request is in the first cycle with `rst`=0.
- Redirect cost:
  - redirect at cycle N with nothing outstanding: request for the target at N+1.
  - with a pending discard: the target request issues in the cycle of the discarded response.
- Reset mid-operation clears everything at the next edge. A ROM response that arrives after reset is ignored.

## Structure
- Package `rv_fetch_pkg`:
  - `INST_NOP` = 32'h0000_0013.
  - `RESET_PC_DEFAULT`.
  - a packed struct {addr[31:0], inst[31:0]} for a fetch entry.
- Sub-module `ifq_fifo`:
  - synchronous FIFO of fetch entries, parameter `DEPTH`.
  - ports: push, pop, clear, count, head.
  - clear has priority over push and pop.
- The top holds the request/discard control and `fetch_pc`.

## Test plan
- Reset then 1-cycle ROM, ready always 1 → requests at 0x0, 0x4, 0x8… on consecutive cycles; `inst_valid_o` from cycle 2; `inst_addr_o` follows at 1/cycle.
- `inst_ready_i`=0, DEPTH=4 → exactly 4 entries queued, `rom_req_o` stays 0. Ready pulsed for 1 cycle → exactly one new request, to 0x10.
- 3-cycle ROM latency, jump to 0x103 while a request is outstanding → response dropped; next request is 0x100, issued in the cycle of the dropped response; next valid output has `inst_addr_o`=0x100.
- `jump_en_i` in the same cycle as `rom_rvalid_i` and a pop → queue empty next cycle, data not pushed, request to the target in the following cycle.
- `fetch_pc` set to 0xFFFF_FFFC via a jump → fetches 0xFFFF_FFFC then 0x0000_0000.
- `rst` asserted with a full queue and an outstanding request, then ROM responds → outputs at reset values, response ignored, first request to `RESET_PC`.
